memory_arbiter: RTL

- Shares the single-port memory_controller between the instruction fetch path and the data (load/store) path of the processor.
- Selects one requester per cycle and drives the memory address-phase signals (addr, wdata, write, size, prot, trans).
- Returns rdata/abort to the requester that owned the transfer one cycle earlier.
- Data has priority. A starvation guard guarantees instruction fetch forward progress.

---
 rtl/memory_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// Fetch/data arbiter in front of the single-port memory controller.
// Data has priority; a bounded data run keeps fetch moving.
module memory_arbiter #(
   parameter int MAX_DATA_RUN = 4,
   parameter int ADDR_W       = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [31:0]       i_rdata,
   output logic              i_abort,
   input  logic              d_req,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [31:0]       d_wdata,
   input  logic              d_write,
   input  logic              d_size,
   input  logic [1:0]        d_prot,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [31:0]       d_rdata,
   output logic              d_abort,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   output logic              mem_write,
   output logic              mem_size,
   output logic [1:0]        mem_prot,
   output logic [1:0]        mem_trans,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_abort
);

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_DATA  = 2'd2
   } owner_e;

   typedef struct packed {
      owner_e            owner;
      logic [ADDR_W-1:0] addr;
      logic              write;
   } xfer_t;

   localparam logic [3:0] RUN_MAX = 4'(MAX_DATA_RUN);
   localparam logic [1:0] TR_IDLE = 2'b00;
   localparam logic [1:0] TR_NSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ  = 2'b11;

   logic [3:0]        data_run, data_run_nxt;
   xfer_t             prev_q, cur;
   logic [ADDR_W-1:0] addr_hold, prev_addr_inc;
   logic [31:0]       wdata_hold;
   logic              fetch_force, seq;

   // Fetch wins a contended cycle only once the data run has hit its limit.
   always_comb begin
      fetch_force = (data_run == RUN_MAX);
      i_gnt = 1'b0;
      d_gnt = 1'b0;
      if (!reset) begin
         if (d_req && !(i_req && fetch_force)) d_gnt = 1'b1;
         else if (i_req)                      i_gnt = 1'b1;
      end
   end

   always_comb begin
      data_run_nxt = data_run;
      if (i_gnt || !i_req)                    data_run_nxt = 4'd0;
      else if (d_gnt && (data_run < RUN_MAX)) data_run_nxt = data_run + 4'd1;
   end

   // Address phase; idle cycles keep the last address and write data on the bus.
   always_comb begin
      cur.owner = OWN_NONE;
      cur.addr  = addr_hold;
      cur.write = 1'b0;
      mem_wdata = wdata_hold;
      mem_size  = 1'b0;
      mem_prot  = 2'b00;
      if (d_gnt) begin
         cur.owner = OWN_DATA;
         cur.addr  = d_addr;
         cur.write = d_write;
         mem_wdata = d_wdata;
         mem_size  = d_size;
         mem_prot  = d_prot;
      end else if (i_gnt) begin
         cur.owner = OWN_FETCH;
         cur.addr  = i_addr;
         mem_wdata = 32'd0;
         mem_size  = 1'b1;
         mem_prot  = 2'b10;
      end
      mem_addr  = cur.addr;
      mem_write = cur.write;
      if (reset) begin
         mem_addr  = '0;
         mem_wdata = 32'd0;
      end
   end

   // Sequential burst: same owner and direction as last cycle, next word up (wraps).
   always_comb begin
      prev_addr_inc = prev_q.addr + ADDR_W'(1);
      seq = (cur.owner != OWN_NONE) && (cur.owner == prev_q.owner) &&
            (cur.write == prev_q.write) && (cur.addr == prev_addr_inc);
      if (cur.owner == OWN_NONE) mem_trans = TR_IDLE;
      else if (seq)              mem_trans = TR_SEQ;
      else                       mem_trans = TR_NSEQ;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_run   <= 4'd0;
         prev_q     <= '0;
         addr_hold  <= '0;
         wdata_hold <= 32'd0;
      end else begin
         data_run   <= data_run_nxt;
         prev_q     <= cur;
         addr_hold  <= mem_addr;
         wdata_hold <= mem_wdata;
      end
   end

   // Response phase: last cycle's owner gets the memory result.
   always_comb begin
      i_rvalid = !reset && (prev_q.owner == OWN_FETCH);
      d_rvalid = !reset && (prev_q.owner == OWN_DATA);
      i_abort  = i_rvalid && mem_abort;
      d_abort  = d_rvalid && mem_abort;
      i_rdata  = mem_rdata;
      d_rdata  = mem_rdata;
   end

endmodule
